// File: rtl/mgmt_phy_link_trainer.sv
// Controller-side LTPI PHY link-training FSM: hunt/detect/speed/advertise/config/operational with retry limit.
// Optional: define LINK_TRAINER_STATS_EN to add saturating lost_total / retrain_total counters.
module mgmt_phy_link_trainer #(
  parameter int unsigned CLK_KHZ     = 60000,
  parameter int unsigned FRAME_LEN   = 15,
  parameter int unsigned OFS_W       = 4,
  parameter int unsigned ADV_MS      = 1,
  parameter int unsigned SPEED_TO_MS = 10,
  parameter int unsigned HUNT_TO_MS  = 100,
  parameter int unsigned MAX_RETRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OFS_W-1:0] tx_frm_offset,
  input  logic             aligned,
  input  logic             frame_crc_err,
  input  logic             crc_consec_loss,
  input  logic             unexpected_frame_error,
  input  logic             detect_locked,
  input  logic             detect_tx_done,
  input  logic             remote_speed_st,
  input  logic             speed_tx_done,
  input  logic             advertise_locked,
  input  logic             auto_move_config,
  input  logic             trigger_config,
  input  logic             cfg_timeout,
  input  logic             accept_rcv,
  input  logic             op_frm_lost,
  input  logic             sw_reset_local,
  input  logic             sw_reset_remote,
  input  logic             retrain_req,
  input  logic             pll_done,
  output logic             pll_reconfig,
  output logic             pll_target_op,
  output logic [3:0]       link_state,
  output logic [7:0]       retry_cnt,
  output logic             link_fail
`ifdef LINK_TRAINER_STATS_EN
  ,
  output logic [15:0]      lost_total,
  output logic [15:0]      retrain_total
`endif
);

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_HUNT      = 4'd1,
    S_DETECT    = 4'd2,
    S_SPEED     = 4'd3,
    S_SPEED_CHG = 4'd4,
    S_ADV       = 4'd5,
    S_WAIT_ADV  = 4'd6,
    S_CONFIG    = 4'd7,
    S_OPER      = 4'd8,
    S_OP_RST    = 4'd9,
    S_LOST      = 4'd10,
    S_FAIL      = 4'd11
  } state_t;

  localparam int unsigned TMR_W     = $clog2(HUNT_TO_MS * CLK_KHZ);
  localparam int unsigned ADV_CYC   = ADV_MS * CLK_KHZ;
  localparam int unsigned SPEED_CYC = SPEED_TO_MS * CLK_KHZ;
  localparam int unsigned HUNT_CYC  = HUNT_TO_MS * CLK_KHZ;
  localparam logic [TMR_W-1:0] ADV_LIM   = TMR_W'(ADV_CYC - 1);
  localparam logic [TMR_W-1:0] SPEED_LIM = TMR_W'(SPEED_CYC - 1);
  localparam logic [TMR_W-1:0] HUNT_LIM  = TMR_W'(HUNT_CYC - 1);
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRIES);
  localparam logic [OFS_W-1:0] FRM_LAST  = OFS_W'(FRAME_LEN);

  state_t           r_state;
  logic [3:0]       r_link_state;
  logic             r_op_flag;
  logic [TMR_W-1:0] r_timer;
  logic             r_pll_reconfig;
  logic             r_pll_target_op;
  logic [7:0]       r_retry;
  logic             r_link_fail;

  state_t           w_next;
  logic             w_op_next;
  logic             w_err;
  logic             w_fb;
  logic [TMR_W-1:0] w_lim;
  logic             w_tmo;
  logic             w_cnt_en;
  logic [7:0]       w_retry_inc;

  assign w_err       = crc_consec_loss | (unexpected_frame_error & ~frame_crc_err);
  assign w_fb        = (tx_frm_offset == FRM_LAST);
  assign w_retry_inc = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;

  // One shared timer; its terminal count depends on which state is using it.
  always_comb begin
    w_lim    = HUNT_LIM;
    w_cnt_en = 1'b0;
    case (r_state)
      S_ADV:   begin w_lim = ADV_LIM;   w_cnt_en = 1'b1;      end
      S_SPEED: begin w_lim = SPEED_LIM; w_cnt_en = 1'b1;      end
      S_HUNT:  begin w_lim = HUNT_LIM;  w_cnt_en = r_op_flag; end
      default: begin w_lim = HUNT_LIM;  w_cnt_en = 1'b0;      end
    endcase
  end

  assign w_tmo = (r_timer == w_lim);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:      if (pll_done) w_next = S_HUNT;
      S_HUNT: begin
        if (aligned)                 w_next = r_op_flag ? S_ADV : S_DETECT;
        else if (r_op_flag && w_tmo) w_next = S_LOST;
      end
      S_DETECT: begin
        if (w_err) w_next = S_LOST;
        else if (((detect_locked && detect_tx_done) || remote_speed_st) && w_fb) w_next = S_SPEED;
      end
      S_SPEED: begin
        if (w_err || w_tmo)             w_next = S_LOST;
        else if (speed_tx_done && w_fb) w_next = S_SPEED_CHG;
      end
      S_SPEED_CHG: if (pll_done) w_next = S_HUNT;
      S_ADV: begin
        if (w_err) w_next = S_LOST;
        else if (w_tmo) begin
          if (!advertise_locked)      w_next = S_LOST;
          else if (!auto_move_config) w_next = S_WAIT_ADV;
          else if (w_fb)              w_next = S_CONFIG;
        end
      end
      S_WAIT_ADV: begin
        if (w_err)                       w_next = S_LOST;
        else if (trigger_config && w_fb) w_next = S_CONFIG;
      end
      S_CONFIG: begin
        if (w_err)                    w_next = S_LOST;
        else if (cfg_timeout && w_fb) w_next = S_ADV;
        else if (accept_rcv && w_fb)  w_next = S_OPER;
      end
      S_OPER: begin
        if (w_err)                                  w_next = S_LOST;
        else if (sw_reset_local || sw_reset_remote) w_next = S_OP_RST;
        else if (retrain_req)                       w_next = S_INIT;
        else if (op_frm_lost)                       w_next = S_LOST;
      end
      S_OP_RST:    if (w_fb) w_next = S_ADV;
      S_LOST:      w_next = (w_retry_inc == RETRY_MAX) ? S_FAIL : S_INIT;
      S_FAIL:      if (retrain_req) w_next = S_INIT;
      default:     w_next = S_INIT;
    endcase
  end

  // Every path into INIT (reset, LOST, FAIL, retrain) implies base speed, so op_flag is 0 there.
  always_comb begin
    w_op_next = r_op_flag;
    if (w_next == S_SPEED_CHG)                   w_op_next = 1'b1;
    else if (w_next == S_INIT || r_state == S_LOST) w_op_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_INIT;
      r_link_state    <= '0;
      r_op_flag       <= 1'b0;
      r_timer         <= '0;
      r_pll_reconfig  <= 1'b0;
      r_pll_target_op <= 1'b0;
      r_retry         <= '0;
      r_link_fail     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_link_state <= r_state;
      r_op_flag    <= w_op_next;
      if (w_next != r_state)     r_timer <= '0;
      else if (w_cnt_en && !w_tmo) r_timer <= r_timer + 1'b1;
      r_pll_reconfig <= (w_next == S_INIT) || (w_next == S_SPEED_CHG);
      if (w_next == S_SPEED_CHG) r_pll_target_op <= 1'b1;
      else if (w_next == S_INIT) r_pll_target_op <= w_op_next;
      r_link_fail <= (w_next == S_FAIL);
      if (r_state == S_LOST) r_retry <= w_retry_inc;
      else if ((r_state == S_CONFIG && w_next == S_OPER) ||
               (r_state == S_FAIL && w_next == S_INIT)) r_retry <= '0;
    end
  end

`ifdef LINK_TRAINER_STATS_EN
  logic [15:0] r_lost_total;
  logic [15:0] r_retrain_total;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lost_total    <= '0;
      r_retrain_total <= '0;
    end else begin
      if (w_next == S_LOST && r_state != S_LOST && r_lost_total != '1)
        r_lost_total <= r_lost_total + 16'd1;
      if (r_state == S_OPER && w_next == S_INIT && r_retrain_total != '1)
        r_retrain_total <= r_retrain_total + 16'd1;
    end
  end

  assign lost_total    = r_lost_total;
  assign retrain_total = r_retrain_total;
`endif

  assign pll_reconfig  = r_pll_reconfig;
  assign pll_target_op = r_pll_target_op;
  assign link_state    = r_link_state;
  assign retry_cnt     = r_retry;
  assign link_fail     = r_link_fail;

endmodule

// File: doc/mgmt_phy_link_trainer.md
Name: mgmt_phy_link_trainer

Overview:
Parametrised successor of the LTPI Controller-side PHY link-training FSM. It drives the link through comma hunting, detect, speed, advertise, configuration and operational states. Compared with the previous generation it adds:
- generic timing and frame length;
- internally generated speed/advertise/hunt timeouts;
- a bounded retry counter with a terminal FAIL state;
- explicit PLL target selection.

It sits between mgmt_ltpi frame RX/TX logic and the PLL reconfiguration block.

Parameters:
CLK_KHZ, 60000, clk frequency in kHz; 1 ms = CLK_KHZ cycles.
FRAME_LEN, 15, tx_frm_offset value marking the last word of a frame.
OFS_W, 4, width of tx_frm_offset.
ADV_MS, 1, advertise dwell time in ms.
SPEED_TO_MS, 10, speed-state timeout in ms.
HUNT_TO_MS, 100, comma-hunt timeout at operational speed in ms.
MAX_RETRIES, 8, consecutive LINK_LOST entries before FAIL (1..255).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tx_frm_offset  in  OFS_W  current TX frame word offset
aligned  in  1  RX comma alignment achieved
frame_crc_err  in  1  CRC error on current frame
crc_consec_loss  in  1  consecutive-CRC-loss error
unexpected_frame_error  in  1  wrong frame type received
detect_locked  in  1  remote detect frames locked
detect_tx_done  in  1  255 detect frames transmitted
remote_speed_st  in  1  remote reports link-speed state
speed_tx_done  in  1  7 speed frames transmitted
advertise_locked  in  1  advertise frames locked
auto_move_config  in  1  CSR: leave advertise automatically
trigger_config  in  1  CSR: manual move to configuration
cfg_timeout  in  1  configuration timeout pulse
accept_rcv  in  1  accept frame received
op_frm_lost  in  1  operational frame-lost error
sw_reset_local  in  1  CSR software reset
sw_reset_remote  in  1  remote software reset
retrain_req  in  1  CSR retraining request (also clears FAIL)
pll_done  in  1  PLL reconfiguration complete
pll_reconfig  out  1  PLL reconfiguration request
pll_target_op  out  1  0 = base speed, 1 = operational speed
link_state  out  4  registered state code
retry_cnt  out  8  consecutive LINK_LOST count
link_fail  out  1  high while in FAIL

Behaviour:
- Definitions:
  - err = crc_consec_loss | (unexpected_frame_error & ~frame_crc_err)
  - fb (frame boundary) = (tx_frm_offset == FRAME_LEN)
- State codes: INIT=0, HUNT=1, DETECT=2, SPEED=3, SPEED_CHG=4, ADV=5, WAIT_ADV=6, CONFIG=7, OPER=8, OP_RST=9, LOST=10, FAIL=11. Codes 12–15 go to INIT next cycle.
- Reset values: state INIT, pll_reconfig 0, pll_target_op 0, retry_cnt 0, link_fail 0, op_flag 0. link_state is the state register delayed one cycle; it resets to 0.
- INIT:
  - Asserts pll_reconfig=1 and pll_target_op=op_flag.
  - On pll_done: pll_reconfig is 0 next cycle, go to HUNT.
- HUNT:
  - aligned & ~op_flag -> DETECT.
  - aligned & op_flag -> ADV.
  - If op_flag and the timer reaches HUNT_TO_MS -> LOST.
  - aligned has priority over timeout in the same cycle.
- DETECT:
  - err -> LOST.
  - Else ((detect_locked & detect_tx_done) | remote_speed_st) & fb -> SPEED.
- SPEED:
  - err, or timer reaches SPEED_TO_MS -> LOST.
  - Else speed_tx_done & fb -> SPEED_CHG.
- SPEED_CHG:
  - Sets op_flag=1 and asserts pll_reconfig with pll_target_op=1.
  - On pll_done: deassert pll_reconfig, go to HUNT.
- ADV:
  - err -> LOST.
  - Timer reaches ADV_MS with advertise_locked:
    - auto_move_config=0 -> WAIT_ADV.
    - auto_move_config=1 -> CONFIG when fb; hold (timer saturated) otherwise.
  - Timer reaches ADV_MS without advertise_locked -> LOST.
- WAIT_ADV:
  - err -> LOST.
  - Else trigger_config & fb -> CONFIG.
- CONFIG:
  - err -> LOST.
  - Else cfg_timeout & fb -> ADV.
  - Else accept_rcv & fb -> OPER.
  - On entry to OPER, retry_cnt clears to 0.
- OPER, priority order:
  1. err -> LOST.
  2. sw_reset_local | sw_reset_remote -> OP_RST.
  3. retrain_req -> INIT, with op_flag cleared.
  4. op_frm_lost -> LOST.
- OP_RST: fb -> ADV.
- LOST:
  - Single cycle; clears op_flag; retry_cnt saturating +1.
  - If the new count == MAX_RETRIES -> FAIL, else -> INIT.
- FAIL:
  - pll_reconfig=0, link_fail=1.
  - retrain_req -> INIT with retry_cnt cleared.
- Timer:
  - Single counter, cleared on every state change; counts only in HUNT (when op_flag), SPEED and ADV; saturates at its limit.
  - Terminal counts: ADV_MS*CLK_KHZ-1 (ADV), SPEED_TO_MS*CLK_KHZ-1 (SPEED), HUNT_TO_MS*CLK_KHZ-1 (HUNT); the comparison uses the limit for the current state.
  - Width is clog2(HUNT_TO_MS*CLK_KHZ).
- Reset asserted in any state returns to INIT on the next edge; pll_reconfig is re-requested with target base.

Optional Feature:
- Macro: LINK_TRAINER_STATS_EN.
- When defined: adds outputs lost_total (16-bit) and retrain_total (16-bit), both saturating and cleared only by reset.
  - lost_total increments on each LOST entry.
  - retrain_total increments on each OPER->INIT transition.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Happy path: reset, pll_done at cycle 3, aligned, detect_locked+detect_tx_done with offset 15, speed_tx_done, pll_done, aligned, advertise_locked, auto_move_config=1, accept_rcv -> link_state sequence 0,1,2,3,4,0-free path 1,5,7,8; pll_target_op=1 after SPEED_CHG.
- Frame gating: speed_tx_done while offset=7 -> stays SPEED until offset=15, then SPEED_CHG on the next edge.
- ADV timeout (CLK_KHZ=10, ADV_MS=1): advertise_locked=0 -> LOST exactly 10 cycles after ADV entry, then INIT with pll_target_op=0.
- Retry exhaustion (MAX_RETRIES=3): force crc_consec_loss in DETECT three times -> retry_cnt 1,2,3, link_fail=1, state 11; retrain_req -> INIT, retry_cnt=0.
- OPER priority: err and sw_reset_local in the same cycle -> LOST; sw_reset_remote alone -> OP_RST -> ADV at offset 15.
- Stats (macro on): two LOST entries and one retrain -> lost_total=2, retrain_total=1; mid-sequence reset clears both to 0.
